block_cipher_pipe: RTL and testbench
====================================

# block_cipher_pipe

Parametrised, streaming substitution-permutation cipher stage: each accepted beat is XORed with an internal LFSR keystream, passed through nibble S-boxes and a bit-permutation P-box, and emitted three cycles later. Adds valid/ready backpressure, runtime reseeding and a per-beat encrypt/decrypt mode. Sits between the audio sample source and the transmit/storage sink, replacing the fixed 8-bit encryption datapath.

## Interface
- W, 8: datapath and LFSR width; one of 8, 16, 32, 64.
- TAPS, 8'hB8: LFSR feedback tap mask, W bits.
- SEED_INIT, 8'h01: LFSR value after reset; must be nonzero.
- STRIDE, 3: P-box stride; odd.

- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- in_valid  in  1  input beat present.
- in_ready  out  1  block accepts beat this cycle.
- in_data  in  W  plaintext (encrypt) or ciphertext (decrypt).
- in_mode  in  1  0 = encrypt, 1 = decrypt; sampled with the beat.
- seed_load  in  1  load seed into LFSR this cycle.
- seed  in  W  new LFSR state.
- out_valid  out  1  output beat present.
- out_ready  in  1  sink accepts beat.
- out_data  out  W  result.

## Operation
- Accept: in_valid && in_ready. Beat captures the current LFSR state ks, in_data and in_mode; LFSR then advances once.
- LFSR: Fibonacci; next = {state[W-2:0], ^(state & TAPS)}. Advances only on accept.
- S-box (per nibble, PRESENT): C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2. Inverse: 5,E,F,8,C,1,2,D,B,4,6,3,0,7,9,A.
- P-box: out[(i*STRIDE) mod W] = in[i]; inverse applies the reverse mapping.
- Encrypt stages: S1 = in_data ^ ks; S2 = Sbox(S1); S3 = Pbox(S2).
- Decrypt stages: S1 = invPbox(in_data); S2 = invSbox(S1); S3 = S2 ^ ks. ks is carried down the pipeline with the beat.
- Mode is per beat; mixed-mode beats may be in flight simultaneously.
- Seed load: LFSR <= seed, or 1 if seed == 0 (lock-up guard). When seed_load coincides with an accept, the beat uses the pre-load state and the load wins over the advance.

## Timing
- Reset (rst low at clk edge): all stage valids 0, out_valid 0, out_data 0, LFSR = SEED_INIT, in_ready 1 on the next cycle. Reset mid-stream discards all in-flight beats.
- Pipeline: 3 register stages, the third drives out_data/out_valid. Latency is 3 cycles from accept to out_valid with no stall. Throughput is 1 beat/clk.
- Stage k loads when it is empty or its contents move forward this cycle. The last stage moves when out_ready.
- in_ready = !S1_valid || S1 moves; combinational from out_ready through the chain.
- With out_ready low and all three stages full, in_ready is 0 and the LFSR holds. out_data/out_valid stay stable while stalled.
- out_data is held after the beat leaves (out_valid 0); the value is don't-care.

## Configuration
- CIPHER_DECRYPT_EN defined: the inverse S-box/P-box paths and the ks side-pipeline for stage 3 are built, and in_mode is honoured.
- Undefined: encrypt only; in_mode is ignored; the ks side-pipeline and inverse tables are removed.

## Structure
- Package cipher_pkg: the S-box and inverse S-box nibble tables, the sbox_w/inv_sbox_w functions over W bits, the pbox/inv_pbox functions (W, STRIDE), and the mode encoding constants.
- Sub-module cipher_keystream_lfsr: W, TAPS and SEED_INIT parameters; ports for advance, seed_load, seed and state.

## Test plan
- Encrypt: W=8, reset, in_data 0x00, mode 0, out_ready 1 -> out_data 0x65 exactly 3 cycles after accept; LFSR then 0x02.
- Round trip: reset, encrypt 0x00..0xFF back-to-back, reset again, decrypt the captured outputs -> 0x00..0xFF in order; one beat/clk with no bubbles.
- Backpressure: out_ready low for 10 cycles during a stream -> in_ready falls after 3 accepts, no beat lost or duplicated, LFSR frozen, out_data stable while stalled.
- Seed: seed_load with seed 0x00 -> LFSR 0x01. seed_load with 0x5A in the same cycle as an accept -> that beat uses the old ks, and the next beat uses 0x5A.
- Reset mid-operation: rst low with 3 beats in flight -> out_valid 0 next cycle, out_data 0x00, LFSR = SEED_INIT, and no stale beat appears afterwards.
- Build without CIPHER_DECRYPT_EN: in_mode 1 with in_data 0x00 -> out 0x65, identical to encrypt.

Source files
------------

// File: rtl/cipher_pkg.sv
// Shared tables and width-generic helpers for the block_cipher_pipe datapath.
// Inverse tables exist only when CIPHER_DECRYPT_EN is defined.
package cipher_pkg;

    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] word_t;

    typedef enum logic {
        MODE_ENC = 1'b0,
        MODE_DEC = 1'b1
    } mode_e;

    // Nibble k of each table holds S[k] (PRESENT S-box).
    localparam logic [63:0] SBOX_TBL = 64'h2174_8FE3_DA09_B65C;

    function automatic word_t sbox_w(input word_t x, input int w);
        word_t r;
        r = '0;
        for (int n = 0; n < w / 4; n++)
            r[4*n +: 4] = SBOX_TBL[4*int'(x[4*n +: 4]) +: 4];
        return r;
    endfunction

    function automatic word_t pbox(input word_t x, input int w, input int stride);
        word_t r;
        r = '0;
        for (int i = 0; i < w; i++)
            r[(i * stride) % w] = x[i];
        return r;
    endfunction

`ifdef CIPHER_DECRYPT_EN
    localparam logic [63:0] INV_SBOX_TBL = 64'hA970_364B_D21C_8FE5;

    function automatic word_t inv_sbox_w(input word_t x, input int w);
        word_t r;
        r = '0;
        for (int n = 0; n < w / 4; n++)
            r[4*n +: 4] = INV_SBOX_TBL[4*int'(x[4*n +: 4]) +: 4];
        return r;
    endfunction

    function automatic word_t inv_pbox(input word_t x, input int w, input int stride);
        word_t r;
        r = '0;
        for (int i = 0; i < w; i++)
            r[i] = x[(i * stride) % w];
        return r;
    endfunction
`endif

endpackage

// File: rtl/cipher_keystream_lfsr.sv
// Fibonacci LFSR keystream: advances once per accepted beat, reloadable at runtime.
module cipher_keystream_lfsr #(
    parameter int             W         = 8,
    parameter logic [W-1:0]   TAPS      = 8'hB8,
    parameter logic [W-1:0]   SEED_INIT = 8'h01
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         advance,
    input  logic         seed_load,
    input  logic [W-1:0] seed,
    output logic [W-1:0] state
);

    logic [W-1:0] state_q, state_d;

    // A load overrides the advance; an all-zero seed would lock the register up.
    always_comb begin
        state_d = state_q;
        if (seed_load)
            state_d = (seed == '0) ? W'(1) : seed;
        else if (advance)
            state_d = {state_q[W-2:0], ^(state_q & TAPS)};
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= SEED_INIT;
        else      state_q <= state_d;
    end

    assign state = state_q;

endmodule

// File: rtl/block_cipher_pipe.sv
// Three-stage streaming SPN cipher with valid/ready backpressure and LFSR keystream.
// Define CIPHER_DECRYPT_EN to build the per-beat decrypt path (in_mode honoured).
module block_cipher_pipe
    import cipher_pkg::*;
#(
    parameter int           W         = 8,
    parameter logic [W-1:0] TAPS      = 8'hB8,
    parameter logic [W-1:0] SEED_INIT = 8'h01,
    parameter int           STRIDE    = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_mode,
    input  logic         seed_load,
    input  logic [W-1:0] seed,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] ks;
    logic         accept;
    logic         s1_en, s2_en, s3_en;
    logic         s1_v_q, s2_v_q, s3_v_q;
    logic [W-1:0] s1_q, s2_q, s3_q;
    logic [W-1:0] s1_d, s2_d, s3_d;

    // Each stage may load when empty or when its occupant leaves this cycle.
    assign s3_en    = !s3_v_q || out_ready;
    assign s2_en    = !s2_v_q || s3_en;
    assign s1_en    = !s1_v_q || s2_en;
    assign in_ready = s1_en;
    assign accept   = in_valid && in_ready;

    cipher_keystream_lfsr #(
        .W         (W),
        .TAPS      (TAPS),
        .SEED_INIT (SEED_INIT)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .advance   (accept),
        .seed_load (seed_load),
        .seed      (seed),
        .state     (ks)
    );

`ifdef CIPHER_DECRYPT_EN
    mode_e        m1_q, m2_q;
    logic [W-1:0] ks1_q, ks2_q;

    assign s1_d = (in_mode == MODE_DEC) ? W'(inv_pbox(word_t'(in_data), W, STRIDE))
                                        : in_data ^ ks;
    assign s2_d = (m1_q == MODE_DEC)    ? W'(inv_sbox_w(word_t'(s1_q), W))
                                        : W'(sbox_w(word_t'(s1_q), W));
    assign s3_d = (m2_q == MODE_DEC)    ? s2_q ^ ks2_q
                                        : W'(pbox(word_t'(s2_q), W, STRIDE));

    always_ff @(posedge clk) begin
        if (accept) begin
            m1_q  <= mode_e'(in_mode);
            ks1_q <= ks;
        end
        if (s2_en && s1_v_q) begin
            m2_q  <= m1_q;
            ks2_q <= ks1_q;
        end
    end
`else
    logic unused_mode;
    assign unused_mode = in_mode;

    assign s1_d = in_data ^ ks;
    assign s2_d = W'(sbox_w(word_t'(s1_q), W));
    assign s3_d = W'(pbox(word_t'(s2_q), W, STRIDE));
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            s3_v_q <= 1'b0;
            s3_q   <= '0;
        end else begin
            if (s1_en) s1_v_q <= accept;
            if (s2_en) s2_v_q <= s1_v_q;
            if (s3_en) s3_v_q <= s2_v_q;
            if (s3_en && s2_v_q) s3_q <= s3_d;
        end
    end

    // NOTE: inner data registers carry no reset; their valid bits already gate them.
    always_ff @(posedge clk) begin
        if (accept)          s1_q <= s1_d;
        if (s2_en && s1_v_q) s2_q <= s2_d;
    end

    assign out_valid = s3_v_q;
    assign out_data  = s3_q;

endmodule

// File: tb/tb_block_cipher_pipe.sv
// Self-checking bench for block_cipher_pipe: behavioural cipher model plus directed literals.
module tb_block_cipher_pipe;

    localparam int         W         = 8;
    localparam int         STRIDE    = 3;
    localparam logic [7:0] TAPS      = 8'hB8;
    localparam logic [7:0] SEED_INIT = 8'h01;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_mode, seed_load, out_valid, out_ready;
    logic [W-1:0] in_data, seed, out_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    block_cipher_pipe #(
        .W (W), .TAPS (TAPS), .SEED_INIT (SEED_INIT), .STRIDE (STRIDE)
    ) dut (
        .clk (clk), .rst (rst),
        .in_valid (in_valid), .in_ready (in_ready), .in_data (in_data), .in_mode (in_mode),
        .seed_load (seed_load), .seed (seed),
        .out_valid (out_valid), .out_ready (out_ready), .out_data (out_data)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference ----------------
    int sb [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};

    function automatic logic [W-1:0] lfsr_next(input logic [W-1:0] s);
        logic fb = 1'b0;
        for (int i = 0; i < W; i++) if (TAPS[i]) fb = fb ^ s[i];
        return {s[W-2:0], fb};
    endfunction

    function automatic logic [W-1:0] enc_m(input logic [W-1:0] d, input logic [W-1:0] k);
        logic [W-1:0] x, y, z;
        x = d ^ k;
        for (int n = 0; n < W / 4; n++) y[4*n +: 4] = 4'(sb[x[4*n +: 4]]);
        for (int i = 0; i < W; i++) z[(i * STRIDE) % W] = y[i];
        return z;
    endfunction

    function automatic logic [W-1:0] dec_m(input logic [W-1:0] d, input logic [W-1:0] k);
        logic [W-1:0] y, x;
        for (int i = 0; i < W; i++) y[i] = d[(i * STRIDE) % W];
        for (int n = 0; n < W / 4; n++)
            for (int j = 0; j < 16; j++)
                if (sb[j] == int'(y[4*n +: 4])) x[4*n +: 4] = 4'(j);
        return x ^ k;
    endfunction

    logic [W-1:0] lfsr_m;
    logic [W-1:0] exp_q [$];
    logic [W-1:0] got_q [$];
    int           got_cyc [$];
    int           cyc = 0;

    // Single compare process: outputs and keystream against the model each cycle.
    always @(negedge clk) begin
        logic [W-1:0] e;
        cyc++;
        if (!rst) begin
            exp_q.delete();
            lfsr_m = SEED_INIT;
        end else begin
            check("ks", 64'(dut.ks), 64'(lfsr_m));
            if (out_valid) begin
                if (exp_q.size() == 0) check("spurious_out_valid", 64'(out_valid), 64'(0));
                else                   check("out_data", 64'(out_data), 64'(exp_q[0]));
                if (out_ready && exp_q.size() > 0) begin
                    got_q.push_back(out_data);
                    got_cyc.push_back(cyc);
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
`ifdef CIPHER_DECRYPT_EN
                e = in_mode ? dec_m(in_data, lfsr_m) : enc_m(in_data, lfsr_m);
`else
                e = enc_m(in_data, lfsr_m);
`endif
                exp_q.push_back(e);
            end
            if (seed_load)                lfsr_m = (seed == '0) ? W'(1) : seed;
            else if (in_valid && in_ready) lfsr_m = lfsr_next(lfsr_m);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; in_valid = 1'b0; seed_load = 1'b0;
        tick(); tick();
        rst = 1'b1;
        got_q.delete();
        got_cyc.delete();
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 100 && exp_q.size() > 0; k++) tick();
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        repeat (4) tick();
    endtask

    task automatic send(input logic [W-1:0] d, input logic m);
        logic acc = 1'b0;
        in_valid = 1'b1; in_data = d; in_mode = m;
        for (int k = 0; k < 100 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            tick();
        end
        check("send_accepted", 64'(acc), 64'(1));
    endtask

    task automatic one_beat(input string name, input logic [W-1:0] d, input logic m,
                            input logic [W-1:0] exp_val);
        int lat = 0;
        do_reset();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = d; in_mode = m;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) check({name, "_ks_after"}, 64'(dut.ks), 64'h02);
            if (out_valid && lat == 0) begin
                lat = k;
                check(name, 64'(out_data), 64'(exp_val));
            end
        end
        check({name, "_latency"}, 64'(lat), 64'(3));
        tick();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] enc_copy [256];
        logic [W-1:0] hold_ks, hold_out;
        int           acc_cnt;

        rst = 1'b0; in_valid = 1'b0; in_data = '0; in_mode = 1'b0;
        seed_load = 1'b0; seed = '0; out_ready = 1'b1;
        tick(); tick(); tick();
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data",  64'(out_data),  64'(0));
        check("rst_ks",        64'(dut.ks),    64'(SEED_INIT));
        rst = 1'b1;
        check("rst_in_ready",  64'(in_ready),  64'(1));

        // Literal pins: first beat after reset uses ks = 0x01.
        one_beat("enc_00", 8'h00, 1'b0, 8'h65);
`ifdef CIPHER_DECRYPT_EN
        one_beat("dec_65", 8'h65, 1'b1, 8'h00);
`else
        one_beat("mode1_ignored", 8'h00, 1'b1, 8'h65);
`endif

        // Back-to-back encrypt stream, no bubbles.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            in_valid = 1'b1; in_data = W'(i); in_mode = 1'b0;
            check("rt_in_ready", 64'(in_ready), 64'(1));
            tick();
        end
        drain();
        check("rt_count", 64'(got_q.size()), 64'(256));
        if (got_q.size() == 256) begin
            check("rt_no_bubbles", 64'(got_cyc[255] - got_cyc[0]), 64'(255));
            for (int i = 0; i < 256; i++) enc_copy[i] = got_q[i];
`ifdef CIPHER_DECRYPT_EN
            do_reset();
            for (int i = 0; i < 256; i++) begin
                in_valid = 1'b1; in_data = enc_copy[i]; in_mode = 1'b1;
                tick();
            end
            drain();
            check("rt_dec_count", 64'(got_q.size()), 64'(256));
            for (int i = 0; i < 256 && i < got_q.size(); i++)
                check("rt_plain", 64'(got_q[i]), 64'(i));
`endif
        end

        // Backpressure: sink stalled for 10 cycles from the start of a stream.
        do_reset();
        out_ready = 1'b0;
        acc_cnt = 0;
        hold_ks = '0; hold_out = '0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_data = W'($urandom); in_mode = 1'(($urandom));
            @(negedge clk);
            if (in_valid && in_ready) acc_cnt++;
            if (c == 4) begin hold_ks = dut.ks; hold_out = out_data; end
            tick();
        end
        check("bp_accepts", 64'(acc_cnt), 64'(3));
        check("bp_lfsr_frozen", 64'(dut.ks), 64'(hold_ks));
        check("bp_out_stable",  64'(out_data), 64'(hold_out));
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) send(W'($urandom), 1'($urandom));
        drain();
        check("bp_total", 64'(got_q.size()), 64'(13));

        // Seed loading.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) send(W'($urandom), 1'b0);
        in_valid = 1'b0;
        seed_load = 1'b1; seed = 8'h00;
        tick();
        seed_load = 1'b0;
        check("seed_zero_guard", 64'(dut.ks), 64'h01);
        in_valid = 1'b1; in_data = 8'h3C; in_mode = 1'b0;
        seed_load = 1'b1; seed = 8'h5A;
        tick();
        seed_load = 1'b0;
        check("seed_5a_loaded", 64'(dut.ks), 64'h5A);
        tick();
        drain();
        check("seed_count", 64'(got_q.size()), 64'(5));
        if (got_q.size() == 5) begin
            check("seed_beat_old_ks", 64'(got_q[3]), 64'hF9);
            check("seed_beat_new_ks", 64'(got_q[4]), 64'hAA);
        end

        // Reset with three beats in flight.
        do_reset();
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = W'($urandom); in_mode = 1'b0;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
        check("mid_rst_out_valid", 64'(out_valid), 64'(0));
        check("mid_rst_out_data",  64'(out_data),  64'(0));
        check("mid_rst_ks",        64'(dut.ks),    64'(SEED_INIT));
        rst = 1'b1;
        out_ready = 1'b1;
        repeat (10) tick();

        // Randomised traffic with mixed modes, stalls and reseeds.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom % 4) != 0;
            in_data   = W'($urandom);
            in_mode   = 1'($urandom);
            out_ready = ($urandom % 3) != 0;
            seed_load = ($urandom % 16) == 0;
            seed      = (($urandom % 4) == 0) ? '0 : W'($urandom);
            tick();
        end
        seed_load = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
